// File: rtl/gpio_ctrl_n_pkg.sv
// Shared definitions for the gpio_ctrl_n GPIO controller: register offsets,
// pin-count limit and CPU data width.
package gpio_ctrl_n_pkg;

  localparam int CPU_WIDTH   = 32;
  localparam int GPIO_MAX_IO = 32;

  localparam logic [7:0] GPIO_DIR_OFS      = 8'h00;
  localparam logic [7:0] GPIO_DOUT_OFS     = 8'h04;
  localparam logic [7:0] GPIO_DIN_OFS      = 8'h08;
  localparam logic [7:0] GPIO_INT_EN_OFS   = 8'h0C;
  localparam logic [7:0] GPIO_INT_TYPE_OFS = 8'h10;
  localparam logic [7:0] GPIO_INT_POL_OFS  = 8'h14;
  localparam logic [7:0] GPIO_INT_STAT_OFS = 8'h18;
  localparam logic [7:0] GPIO_DOUT_SET_OFS = 8'h1C;
  localparam logic [7:0] GPIO_DOUT_CLR_OFS = 8'h20;

  // Word index of a byte offset, matching the addr_i[7:2] decode.
  function automatic logic [5:0] reg_idx(input logic [7:0] ofs);
    return ofs[7:2];
  endfunction

endpackage

// File: rtl/gpio_ctrl_n_in_cond.sv
// Per-pin input conditioning: synchroniser, optional debounce (GPIO_DEBOUNCE_EN),
// previous-sample flop and primed rise/fall detection.
module gpio_in_cond #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic primed,
  input  logic pin,
  output logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   prev_q;
  logic                   prev_src;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             db_q;
  logic [CNT_W-1:0] db_cnt_q;

  // While priming, the debounced value and prev follow the synchroniser
  // directly so a level present through reset is not reported as an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_q     <= 1'b0;
      db_cnt_q <= '0;
    end else if (!primed) begin
      db_q     <= sync_out;
      db_cnt_q <= '0;
    end else if (sync_out != db_q) begin
      if (db_cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        db_q     <= sync_out;
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + 1'b1;
      end
    end else begin
      db_cnt_q <= '0;
    end
  end

  assign din      = db_q;
  assign prev_src = primed ? db_q : sync_out;
`else
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

  assign din      = sync_out;
  assign prev_src = sync_out;
`endif

  always_ff @(posedge clk) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= prev_src;
  end

  assign rise = primed &  din & ~prev_q;
  assign fall = primed & ~din &  prev_q;

endmodule

// File: rtl/gpio_ctrl_n.sv
// Parametrised GPIO controller on a rib slave port: direction, output data,
// synchronised inputs and per-pin edge/level interrupts with W1C status.
// Optional input debounce is built when GPIO_DEBOUNCE_EN is defined.
module gpio_ctrl_n
  import gpio_ctrl_n_pkg::*;
#(
  parameter int NUM_IO          = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [CPU_WIDTH-1:0]  addr_i,
  input  logic [CPU_WIDTH-1:0]  data_i,
  output logic [CPU_WIDTH-1:0]  data_o,
  input  logic [NUM_IO-1:0]     io_in_i,
  output logic [NUM_IO-1:0]     io_out_o,
  output logic [NUM_IO-1:0]     io_oe_o,
  output logic                  int_o
);

  localparam int PRIME_MAX = SYNC_STAGES + 1;
  localparam int PRIME_W   = (PRIME_MAX > 3) ? 3 : 2;

  localparam logic [5:0] IDX_DIR      = reg_idx(GPIO_DIR_OFS);
  localparam logic [5:0] IDX_DOUT     = reg_idx(GPIO_DOUT_OFS);
  localparam logic [5:0] IDX_DIN      = reg_idx(GPIO_DIN_OFS);
  localparam logic [5:0] IDX_INT_EN   = reg_idx(GPIO_INT_EN_OFS);
  localparam logic [5:0] IDX_INT_TYPE = reg_idx(GPIO_INT_TYPE_OFS);
  localparam logic [5:0] IDX_INT_POL  = reg_idx(GPIO_INT_POL_OFS);
  localparam logic [5:0] IDX_INT_STAT = reg_idx(GPIO_INT_STAT_OFS);
  localparam logic [5:0] IDX_DOUT_SET = reg_idx(GPIO_DOUT_SET_OFS);
  localparam logic [5:0] IDX_DOUT_CLR = reg_idx(GPIO_DOUT_CLR_OFS);

  logic [NUM_IO-1:0]  dir_q, dout_q, int_en_q, int_type_q, int_pol_q, int_stat_q;
  logic [NUM_IO-1:0]  din, rise, fall, stat_set, w1c_mask, wdata, rdata;
  logic [5:0]         idx;
  logic [PRIME_W-1:0] prime_cnt_q;
  logic               primed;
  logic               unused_bits;

  // rib handshake: no valid/ready; a write completes at the clk edge where
  // we_i=1, a read returns data_o combinationally from addr_i with no wait.
  assign idx         = addr_i[7:2];
  assign wdata       = data_i[NUM_IO-1:0];
  assign unused_bits = &{1'b0, addr_i[CPU_WIDTH-1:8], addr_i[1:0], data_i};

  always_ff @(posedge clk) begin
    if (rst)          prime_cnt_q <= '0;
    else if (!primed) prime_cnt_q <= prime_cnt_q + 1'b1;
  end

  assign primed = (prime_cnt_q == PRIME_W'(PRIME_MAX));

  for (genvar i = 0; i < NUM_IO; i++) begin : g_pin
    gpio_in_cond #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_in_cond (
      .clk   (clk),
      .rst   (rst),
      .primed(primed),
      .pin   (io_in_i[i]),
      .din   (din[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end

  // Level mode: polarity 0 = high, 1 = low, hence din ^ pol.
  assign stat_set = ~dir_q & ((int_type_q & ((~int_pol_q & rise) | (int_pol_q & fall)))
                            | (~int_type_q & (din ^ int_pol_q)));
  assign w1c_mask = (we_i && idx == IDX_INT_STAT) ? wdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q      <= '0;
      dout_q     <= '0;
      int_en_q   <= '0;
      int_type_q <= '0;
      int_pol_q  <= '0;
      int_stat_q <= '0;
    end else begin
      if (we_i) begin
        case (idx)
          IDX_DIR:      dir_q      <= wdata;
          IDX_DOUT:     dout_q     <= wdata;
          IDX_INT_EN:   int_en_q   <= wdata;
          IDX_INT_TYPE: int_type_q <= wdata;
          IDX_INT_POL:  int_pol_q  <= wdata;
          IDX_DOUT_SET: dout_q     <= dout_q | wdata;
          IDX_DOUT_CLR: dout_q     <= dout_q & ~wdata;
          default: ;
        endcase
      end
      // Set wins over a same-cycle W1C clear.
      int_stat_q <= (int_stat_q & ~w1c_mask) | stat_set;
    end
  end

  always_comb begin
    rdata = '0;
    case (idx)
      IDX_DIR:      rdata = dir_q;
      IDX_DOUT:     rdata = dout_q;
      IDX_DIN:      rdata = din;
      IDX_INT_EN:   rdata = int_en_q;
      IDX_INT_TYPE: rdata = int_type_q;
      IDX_INT_POL:  rdata = int_pol_q;
      IDX_INT_STAT: rdata = int_stat_q;
      default:      rdata = '0;
    endcase
  end

  assign data_o   = CPU_WIDTH'(rdata);
  assign io_out_o = dout_q;
  assign io_oe_o  = dir_q;
  assign int_o    = |(int_stat_q & int_en_q);

endmodule

// File: tb/tb_gpio_ctrl_n.sv
// Self-checking bench for gpio_ctrl_n: directed drivers push expected values
// into a scoreboard queue that a negedge monitor pops and compares.
module tb_gpio_ctrl_n;
  import gpio_ctrl_n_pkg::*;

  localparam int DB = 4;
`ifdef GPIO_DEBOUNCE_EN
  localparam int DB_LAT = DB;
`else
  localparam int DB_LAT = 0;
`endif

  localparam int SEL_DATA  = 0;
  localparam int SEL_OUT   = 1;
  localparam int SEL_OE    = 2;
  localparam int SEL_INT   = 3;
  localparam int SEL_DATA8 = 4;

  // ---------------- clock / reset / DUTs ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        we_i;
  logic [31:0] addr_i, data_i, data_o;
  logic [15:0] io_in_i, io_out_o, io_oe_o;
  logic        int_o;

  logic        we8;
  logic [31:0] addr8, data8_i, data8_o;
  logic [7:0]  io_in8, io_out8, io_oe8;
  logic        int8;

  always #5 clk = ~clk;

  gpio_ctrl_n #(.NUM_IO(16), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .we_i(we_i), .addr_i(addr_i), .data_i(data_i),
    .data_o(data_o), .io_in_i(io_in_i), .io_out_o(io_out_o),
    .io_oe_o(io_oe_o), .int_o(int_o)
  );

  gpio_ctrl_n #(.NUM_IO(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(DB)) dut8 (
    .clk(clk), .rst(rst), .we_i(we8), .addr_i(addr8), .data_i(data8_i),
    .data_o(data8_o), .io_in_i(io_in8), .io_out_o(io_out8),
    .io_oe_o(io_oe8), .int_o(int8)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int          sel_q[$];
  string       name_q[$];
  logic        chk_stb;
  int          n_cmp;
  int          n_err;
  logic [31:0] m_exp, m_act;
  int          m_sel;
  string       m_name;

  always @(negedge clk) begin
    if (chk_stb) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard_underflow: no expected value queued");
      end else begin
        m_exp  = exp_q.pop_front();
        m_sel  = sel_q.pop_front();
        m_name = name_q.pop_front();
        case (m_sel)
          SEL_DATA:  m_act = data_o;
          SEL_OUT:   m_act = {16'h0, io_out_o};
          SEL_OE:    m_act = {16'h0, io_oe_o};
          SEL_INT:   m_act = {31'h0, int_o};
          SEL_DATA8: m_act = data8_o;
          default:   m_act = 'x;
        endcase
        if (m_act !== m_exp) begin
          n_err++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", m_name, m_act, m_exp);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input int sel, input logic [31:0] exp, input string name);
    exp_q.push_back(exp);
    sel_q.push_back(sel);
    name_q.push_back(name);
    chk_stb = 1'b1;
    tick();
    chk_stb = 1'b0;
  endtask

  task automatic wr(input logic [7:0] ofs, input logic [31:0] d);
    we_i   = 1'b1;
    addr_i = {24'h0, ofs};
    data_i = d;
    tick();
    we_i   = 1'b0;
  endtask

  task automatic rd(input logic [7:0] ofs, input logic [31:0] exp, input string name);
    addr_i = {24'h0, ofs};
    expect_val(SEL_DATA, exp, name);
  endtask

  task automatic wr8(input logic [7:0] ofs, input logic [31:0] d);
    we8     = 1'b1;
    addr8   = {24'h0, ofs};
    data8_i = d;
    tick();
    we8     = 1'b0;
  endtask

  task automatic rd8(input logic [7:0] ofs, input logic [31:0] exp, input string name);
    addr8 = {24'h0, ofs};
    expect_val(SEL_DATA8, exp, name);
  endtask

  task automatic report();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  endtask

  initial begin
    #400000;
    n_cmp++;
    n_err++;
    $display("FAIL watchdog: time limit reached before end of test");
    report();
  end

  // ---------------- stimulus ----------------
  initial begin
    n_cmp   = 0;
    n_err   = 0;
    chk_stb = 1'b0;
    rst     = 1'b1;
    we_i    = 1'b0;
    addr_i  = '0;
    data_i  = '0;
    io_in_i = '0;
    we8     = 1'b0;
    addr8   = '0;
    data8_i = '0;
    io_in8  = '0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state: every offset (mapped, write-only, unmapped) reads 0
    for (int a = 0; a <= 'h28; a += 4) rd(8'(a), 32'h0, $sformatf("reset_read_%02h", a));
    expect_val(SEL_OE,  32'h0, "reset_io_oe");
    expect_val(SEL_OUT, 32'h0, "reset_io_out");
    expect_val(SEL_INT, 32'h0, "reset_int_o");

    // Pins held high through reset, edge mode selected right after reset
    rst     = 1'b1;
    io_in_i = 16'hFFFF;
    repeat (3) tick();
    rst = 1'b0;
    wr(GPIO_INT_TYPE_OFS, 32'h0000_FFFF);
    repeat (8 + DB_LAT) tick();
    rd(GPIO_INT_STAT_OFS, 32'h0, "prime_no_rise");
    rd(GPIO_DIN_OFS, 32'h0000_FFFF, "din_high");
    io_in_i = 16'h0000;
    repeat (4 + DB_LAT) tick();
    rd(GPIO_INT_STAT_OFS, 32'h0, "falling_not_rising");

    // Output path
    wr(GPIO_DIR_OFS, 32'h0000_000F);
    expect_val(SEL_OE, 32'h0000_000F, "io_oe_dir");
    wr(GPIO_DOUT_OFS, 32'h0000_0005);
    expect_val(SEL_OUT, 32'h0000_0005, "io_out_dout");
    wr(GPIO_DOUT_SET_OFS, 32'h0000_0002);
    expect_val(SEL_OUT, 32'h0000_0007, "io_out_set");
    wr(GPIO_DOUT_CLR_OFS, 32'h0000_0001);
    expect_val(SEL_OUT, 32'h0000_0006, "io_out_clr");
    rd(GPIO_DOUT_OFS, 32'h0000_0006, "dout_read");
    rd(GPIO_DOUT_SET_OFS, 32'h0, "dout_set_reads_0");
    wr(8'h24, 32'h0000_FFFF);
    rd(GPIO_DIR_OFS, 32'h0000_000F, "unmapped_write_ignored");

    // Output pin masking
    wr(GPIO_DIR_OFS, 32'h0000_0004);
    io_in_i[2] = 1'b1;
    repeat (3 + DB_LAT) tick();
    rd(GPIO_DIN_OFS, 32'h0000_0004, "din_output_pin");
    rd(GPIO_INT_STAT_OFS, 32'h0, "output_pin_masked");
    io_in_i[2] = 1'b0;
    repeat (3 + DB_LAT) tick();

    // Rising-edge interrupt on pin 3: pin changes just before edge k
    wr(GPIO_INT_POL_OFS, 32'h0);
    wr(GPIO_INT_EN_OFS, 32'h0000_0008);
    io_in_i[3] = 1'b1;
    tick();
    tick();
    repeat (DB_LAT) tick();
    rd(GPIO_INT_STAT_OFS, 32'h0, "stat_before_k2");
    expect_val(SEL_INT, 32'h1, "int_o_after_k2");
    rd(GPIO_INT_STAT_OFS, 32'h0000_0008, "stat_rise");
    wr(GPIO_INT_STAT_OFS, 32'h0000_0008);
    expect_val(SEL_INT, 32'h0, "int_o_after_w1c");
    rd(GPIO_INT_STAT_OFS, 32'h0, "stat_after_w1c");

    // Level-low interrupt on pin 0 and W1C collision
    wr(GPIO_INT_TYPE_OFS, 32'h0000_FFFE);
    wr(GPIO_INT_POL_OFS, 32'h0000_0001);
    wr(GPIO_INT_EN_OFS, 32'h0000_0009);
    rd(GPIO_INT_STAT_OFS, 32'h0000_0001, "level_low_set");
    expect_val(SEL_INT, 32'h1, "int_o_level");
    wr(GPIO_INT_STAT_OFS, 32'h0000_0001);
    rd(GPIO_INT_STAT_OFS, 32'h0000_0001, "w1c_collision_set_wins");
    io_in_i[0] = 1'b1;
    repeat (4 + DB_LAT) tick();
    wr(GPIO_INT_STAT_OFS, 32'h0000_0001);
    rd(GPIO_INT_STAT_OFS, 32'h0, "level_released_cleared");
    expect_val(SEL_INT, 32'h0, "int_o_level_cleared");

    // Reset mid-operation drops pending status and configuration
    io_in_i[0] = 1'b0;
    repeat (3 + DB_LAT) tick();
    rd(GPIO_INT_STAT_OFS, 32'h0000_0001, "stat_before_reset");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rd(GPIO_INT_STAT_OFS, 32'h0, "stat_after_reset");
    rd(GPIO_DIR_OFS, 32'h0, "dir_after_reset");

    // NUM_IO = 8 instance: bits at and above NUM_IO ignore writes
    wr8(GPIO_DIR_OFS, 32'hFFFF_FFFF);
    rd8(GPIO_DIR_OFS, 32'h0000_00FF, "dir_num_io8");
    wr8(GPIO_DOUT_SET_OFS, 32'hFFFF_FF00);
    rd8(GPIO_DOUT_OFS, 32'h0, "dout_upper_ignored8");
    wr8(GPIO_DIR_OFS, 32'h0);

`ifdef GPIO_DEBOUNCE_EN
    // Debounce: 3-cycle glitch filtered, 6-cycle pulse accepted
    repeat (4) tick();
    io_in8[0] = 1'b1;
    repeat (3) tick();
    io_in8[0] = 1'b0;
    repeat (10) tick();
    rd8(GPIO_DIN_OFS, 32'h0, "glitch_3_filtered");
    io_in8[0] = 1'b1;
    repeat (6) tick();
    io_in8[0] = 1'b0;
    rd8(GPIO_DIN_OFS, 32'h0000_0001, "pulse_6_accepted");
    repeat (10) tick();
`endif

    repeat (2) tick();
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_leftover: %0d entries remaining, 0 required", exp_q.size());
    end
    report();
  end

endmodule
